// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between
// two requesters. Operands and results are registered around the ALU.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_req{0,1}_valid/o_req_ready    request handshake, operands and op
//   o_rsp{0,1}_valid/i_rsp_ready    response handshake, result data
//   o_alu_operand_a/b, o_alu_op     registered operands to the ALU
//   i_alu_data                      combinational ALU result
//   o_busy                          high while an op is in flight
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_operand_a,
  input  logic [DATA_W-1:0] i_req0_operand_b,
  input  logic [OP_W-1:0]   i_req0_alu_op,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_operand_a,
  input  logic [DATA_W-1:0] i_req1_operand_b,
  input  logic [OP_W-1:0]   i_req1_alu_op,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic [DATA_W-1:0] o_alu_operand_a,
  output logic [DATA_W-1:0] o_alu_operand_b,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic is_idle;
  logic is_resp;
  logic gnt1;
  logic accept;
  logic rsp_ready;

  assign is_idle = (state_q == IDLE);
  assign is_resp = (state_q == RESP);

  // req1 wins when it is the only one valid, or when both are valid
  // and the round-robin pointer favours it.
  assign gnt1   = i_req1_valid & (~i_req0_valid | rr_q);
  assign accept = is_idle & (i_req0_valid | i_req1_valid);

  // Ready is masked while reset is held so no handshake is reported
  // against a design that is being cleared.
  assign o_req0_ready = i_rst_n & accept & ~gnt1;
  assign o_req1_ready = i_rst_n & accept & gnt1;

  assign o_rsp0_valid = is_resp & ~owner_q;
  assign o_rsp1_valid = is_resp & owner_q;
  assign o_rsp0_data  = res_q;
  assign o_rsp1_data  = res_q;

  assign rsp_ready = owner_q ? i_rsp1_ready : i_rsp0_ready;

  assign o_alu_operand_a = opa_q;
  assign o_alu_operand_b = opb_q;
  assign o_alu_op        = op_q;
  assign o_busy          = ~is_idle;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt1;
          opa_d   = gnt1 ? i_req1_operand_a : i_req0_operand_a;
          opb_d   = gnt1 ? i_req1_operand_b : i_req0_operand_b;
          op_d    = gnt1 ? i_req1_alu_op : i_req0_alu_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = i_alu_data;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

endmodule
